// File: rtl/pulse_pkg.sv
// Shared definitions for the pulse stretcher and its helpers:
// FSM state type, default cycle constants and the counter width helper.
package pulse_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HIGH = 2'd1,
    GAP  = 2'd2
  } stretch_state_t;

  localparam int DEFAULT_HIGH_CYCLES = 1000000;
  localparam int DEFAULT_GAP_CYCLES  = 1000000;
  localparam int DEFAULT_PEND_WIDTH  = 4;

  // Counter must hold the larger of the two reload values; never narrower than 1 bit.
  function automatic int cnt_width(input int high_cycles, input int gap_cycles);
    int longest;
    longest = (high_cycles > gap_cycles) ? high_cycles : gap_cycles;
    return (longest > 1) ? $clog2(longest) : 1;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for synchronous button-path levels.
// o_rise is high for the single cycle in which i_level is 1 and was 0 on the previous cycle,
// so a level held high for many cycles yields exactly one event.
module rise_detect (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_level,
  output logic o_rise
);

  logic r_level_q;

  // Remember last cycle's level so a 0->1 transition can be spotted
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_level_q <= 1'b0;
    end else begin
      r_level_q <= i_level;
    end
  end

  assign o_rise = i_level & ~r_level_q;

endmodule

// File: rtl/pulse_stretcher.sv
// Stretches one-cycle step events into HIGH_CYCLES-long output pulses separated by at
// least GAP_CYCLES low cycles. Events that arrive while a pulse is in progress are
// counted in a saturating pending queue and replayed back to back.
// Optional feature: define PULSE_STRETCH_QUEUE_EN to build the pending queue; without it,
// events during busy are dropped, o_pending reads 0 and o_overflow flags every drop.
module pulse_stretcher
  import pulse_pkg::*;
#(
  parameter int HIGH_CYCLES = DEFAULT_HIGH_CYCLES,
  parameter int GAP_CYCLES  = DEFAULT_GAP_CYCLES,
  parameter int PEND_WIDTH  = DEFAULT_PEND_WIDTH
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_trigger,
  input  logic                  i_clear,
  output logic                  o_stretched,
  output logic                  o_busy,
  output logic [PEND_WIDTH-1:0] o_pending,
  output logic                  o_overflow
);

  localparam int               CNT_W     = cnt_width(HIGH_CYCLES, GAP_CYCLES);
  localparam logic [CNT_W-1:0] HIGH_LOAD = CNT_W'(HIGH_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD  = CNT_W'(GAP_CYCLES - 1);

  stretch_state_t   r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_stretched;
  logic             r_busy;
  logic             r_overflow;

  logic w_event;
  logic w_busy_event;
  logic w_cnt_zero;
  logic w_gap_end;
  logic w_dequeue;

  rise_detect u_rise_detect (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_level (i_trigger),
    .o_rise  (w_event)
  );

  // r_busy mirrors "state is HIGH or GAP", so an event seen while busy is a queue request
  assign w_busy_event = w_event & r_busy;
  assign w_cnt_zero   = (r_cnt == '0);
  assign w_gap_end    = (r_state == GAP) & w_cnt_zero;

`ifdef PULSE_STRETCH_QUEUE_EN
  localparam logic [PEND_WIDTH-1:0] PEND_MAX = '1;

  logic [PEND_WIDTH-1:0] r_pending;

  // A new pulse follows the gap if something is queued, or if an event lands in the
  // very last gap cycle (it is queued and consumed on the same edge). Clear wins.
  assign w_dequeue = w_gap_end & ~i_clear & ((r_pending != '0) | w_busy_event);

  // Saturating pending counter; a coincident enqueue and dequeue cancel out
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_pending  <= '0;
      r_overflow <= 1'b0;
    end else if (i_clear) begin
      r_pending  <= '0;
      r_overflow <= 1'b0;
    end else if (w_busy_event && w_dequeue) begin
      r_pending <= r_pending;
    end else if (w_busy_event) begin
      if (r_pending != PEND_MAX) begin
        r_pending <= r_pending + PEND_WIDTH'(1);
      end else begin
        r_overflow <= 1'b1;
      end
    end else if (w_dequeue) begin
      r_pending <= r_pending - PEND_WIDTH'(1);
    end
  end

  assign o_pending = r_pending;
`else
  assign w_dequeue = 1'b0;

  // Without a queue every event during busy is lost and flagged; clear still wins
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_overflow <= 1'b0;
    end else if (i_clear) begin
      r_overflow <= 1'b0;
    end else if (w_busy_event) begin
      r_overflow <= 1'b1;
    end
  end

  assign o_pending = '0;
`endif

  // Main sequencer: IDLE -> HIGH (HIGH_CYCLES) -> GAP (GAP_CYCLES) -> HIGH or IDLE
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_stretched <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_event) begin
            r_state     <= HIGH;
            r_cnt       <= HIGH_LOAD;
            r_stretched <= 1'b1;
            r_busy      <= 1'b1;
          end
        end
        HIGH: begin
          if (w_cnt_zero) begin
            r_state     <= GAP;
            r_cnt       <= GAP_LOAD;
            r_stretched <= 1'b0;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        GAP: begin
          if (w_cnt_zero) begin
            if (w_dequeue) begin
              r_state     <= HIGH;
              r_cnt       <= HIGH_LOAD;
              r_stretched <= 1'b1;
            end else begin
              r_state <= IDLE;
              r_busy  <= 1'b0;
            end
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_state     <= IDLE;
          r_cnt       <= '0;
          r_stretched <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign o_stretched = r_stretched;
  assign o_busy      = r_busy;
  assign o_overflow  = r_overflow;

endmodule
